stage_wb_lsu: RTL
=================

# stage_wb_lsu

Parametrised writeback stage with an integrated load-return unit. It sits at the end of the pipeline and accepts one instruction per cycle from the execute/memory stage. It aligns and sign-extends load data returned by a data memory with variable latency, stalling upstream while a load is outstanding. It drives a registered register-file write port that also serves as the forwarding source.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- RAW, 5, register address width
- OFFW, $clog2(XLEN/8), byte-offset width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  instruction present in W
- ready_out  out  1  W can accept; transfer when valid_in && ready_out
- wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 CSR/none
- reg_write  in  1  instruction writes rd
- rd  in  RAW  destination register
- alu_out  in  XLEN  ALU result; also load address
- pc_plus4  in  XLEN  link value
- funct3  in  3  load size/sign
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  XLEN  raw memory word, naturally aligned
- csr_rdata  in  XLEN  CSR read data; present only with WB_CSR_EN
- rf_we  out  1  register-file write enable
- rf_waddr  out  RAW  write address
- rf_wdata  out  XLEN  write data
- load_err  out  1  one-cycle pulse on misaligned load or illegal funct3
- retire  out  1  one-cycle pulse per completed instruction

## Operation
- States: IDLE and WAIT_LOAD. ready_out = rst_n && state==IDLE.
- IDLE, transfer with wb_sel!=01: compute the result, register it to rf_*, pulse retire, stay in IDLE.
- IDLE, transfer with wb_sel==01 and mem_rvalid high in the same cycle: complete immediately using mem_rdata.
- IDLE, transfer with wb_sel==01 and mem_rvalid low: latch rd, reg_write, funct3 and alu_out[OFFW-1:0]. Go to WAIT_LOAD.
- WAIT_LOAD: hold until mem_rvalid. On mem_rvalid, format the latched load, register it, pulse retire, return to IDLE. valid_in is ignored in this state. There is no timeout.
- mem_rvalid while IDLE with no load transfer is ignored.
- Load format: offset selects the byte lane in mem_rdata.
  - 000 LB and 100 LBU: byte, sign- or zero-extended to XLEN.
  - 001 LH and 101 LHU: half, sign- or zero-extended.
  - 010 LW: word, sign-extended.
  - XLEN=64 only: 110 LWU (zero-extended) and 011 LD.
- Misaligned when the offset is not a multiple of the access size.
- Misaligned load or illegal funct3: rf_we=0, load_err=1, retire=1, data forced to 0.
- rf_we = reg_write && rd!=0 && !err. rf_waddr and rf_wdata always update on completion, even when rf_we=0.
- wb_sel 11 without WB_CSR_EN: data is 0 and rf_we follows the rule above.

## Timing
- Reset (rst_n low at clk edge): state IDLE; rf_we, rf_waddr, rf_wdata, load_err and retire are 0; latched load fields are 0. ready_out is 0 combinationally while rst_n is low.
- Reset during WAIT_LOAD abandons the pending load. A later mem_rvalid is ignored.
- Non-load latency: rf_* valid in the cycle after the transfer edge.
- Load latency: rf_* valid in the cycle after the mem_rvalid edge, giving N+1 cycles when data returns N cycles after transfer.
- rf_we, load_err and retire are single-cycle pulses. Back-to-back non-load transfers give continuous pulses, one per cycle.
- The cycle after a load completes, ready_out is 1 again, so a new transfer is possible on the very next edge.

## Configuration
- WB_CSR_EN defined: the csr_rdata port exists and wb_sel 11 selects csr_rdata.
- WB_CSR_EN undefined: the port is absent and wb_sel 11 yields data 0.

## Structure
- Package wb_pkg holds:
  - wb_sel encodings WB_ALU, WB_MEM, WB_PC4, WB_CSR;
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU;
  - state enum wb_state_t.
- Sub-module wb_load_align is purely combinational. Inputs: rdata, offset, funct3. Outputs: data, err.
- The FSM, latches, output registers and result mux live in stage_wb_lsu.

## Test plan
- Reset, then ALU op: wb_sel=00, rd=5, alu_out=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, retire=1.
- LB with mem_rdata=0x80FF7F01, offset 3, mem_rvalid 3 cycles later -> ready_out=0 for 3 cycles, then wdata=0xFFFFFF80.
- LHU with offset 2, same-cycle rvalid, rdata=0x8001_0000 -> wdata=0x00008001, no stall.
- LW at offset 2 -> load_err=1, rf_we=0, retire=1.
- rd=0 JAL (wb_sel=10, pc_plus4=0x104) -> rf_we=0, wdata=0x104.
- rst_n low in WAIT_LOAD, later mem_rvalid -> no rf_we, and ready_out=1 after reset.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback / load-return stage.
// Holds the wb_sel encodings, load funct3 codes, the FSM state type and
// a helper that maps a load funct3 to its byte-offset alignment mask.
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } wb_state_t;

  // Low funct3 bits encode log2(access size); offset bits under the mask must be 0.
  function automatic logic [2:0] align_mask(input logic [2:0] f3);
    logic [2:0] m;
    case (f3[1:0])
      2'b00:   m = 3'b000;
      2'b01:   m = 3'b001;
      2'b10:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load formatter.
// Selects the byte lane given by offset from a naturally aligned memory
// word, sign/zero-extends it according to funct3 and flags misaligned or
// illegal accesses. On error the data output is forced to zero.
//   rdata  : raw memory word
//   offset : byte offset of the access within the word
//   funct3 : load size/sign
//   data   : formatted XLEN result (0 on error)
//   err    : misaligned access or illegal funct3
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);

  localparam bit IS64 = (XLEN == 64);

  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] fmt;
  logic            illegal;
  logic            misaligned;

  // Shift the addressed byte lane down to bit 0, then extend by access type.
  always_comb begin
    lane       = rdata >> {offset, 3'b000};
    fmt        = '0;
    illegal    = 1'b0;
    misaligned = (3'(offset) & align_mask(funct3)) != 3'b000;
    case (funct3)
      F3_LB:  fmt = XLEN'($signed(lane[7:0]));
      F3_LBU: fmt = XLEN'(lane[7:0]);
      F3_LH:  fmt = XLEN'($signed(lane[15:0]));
      F3_LHU: fmt = XLEN'(lane[15:0]);
      F3_LW:  fmt = XLEN'($signed(lane[31:0]));
      F3_LWU: begin
        fmt     = XLEN'(lane[31:0]);
        illegal = !IS64;
      end
      F3_LD: begin
        fmt     = lane;
        illegal = !IS64;
      end
      default: illegal = 1'b1;
    endcase
    err  = illegal || misaligned;
    data = err ? '0 : fmt;
  end

endmodule

// File: rtl/stage_wb_lsu.sv
// Writeback stage with integrated load-return unit.
// Accepts one instruction per cycle, selects the writeback value, waits for
// variable-latency load data while stalling upstream, and drives a registered
// register-file write port (also the forwarding source).
// Optional feature macro: WB_CSR_EN adds csr_rdata and makes wb_sel 11 select it.
//   valid_in/ready_out       : upstream handshake (ready_out is combinational)
//   wb_sel, reg_write, rd    : writeback control
//   alu_out, pc_plus4        : result sources; alu_out is also the load address
//   funct3                   : load size/sign
//   mem_rvalid, mem_rdata    : load return (single-cycle pulse)
//   csr_rdata                : CSR read data (WB_CSR_EN only)
//   rf_we, rf_waddr, rf_wdata: registered register-file write port
//   load_err, retire         : registered one-cycle completion pulses
module stage_wb_lsu
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5,
  parameter int unsigned OFFW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [1:0]      wb_sel,
  input  logic            reg_write,
  input  logic [RAW-1:0]  rd,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [2:0]      funct3,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
`ifdef WB_CSR_EN
  input  logic [XLEN-1:0] csr_rdata,
`endif
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err,
  output logic            retire
);

  wb_state_t       state_q, state_d;
  logic [RAW-1:0]  ld_rd_q, ld_rd_d;
  logic            ld_we_q, ld_we_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [OFFW-1:0] ld_off_q, ld_off_d;

  logic            rf_we_q, rf_we_d;
  logic [RAW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            load_err_q, load_err_d;
  logic            retire_q, retire_d;

  logic [OFFW-1:0] al_off;
  logic [2:0]      al_f3;
  logic [XLEN-1:0] al_data;
  logic            al_err;
  logic [XLEN-1:0] nonload_res;

  logic            cmp_c;
  logic [RAW-1:0]  cmp_rd;
  logic            cmp_we;
  logic [XLEN-1:0] cmp_data;
  logic            cmp_err;

  assign ready_out = rst_n && (state_q == S_IDLE);

  // The formatter sees live fields for same-cycle returns, latched ones while waiting.
  assign al_off = (state_q == S_IDLE) ? alu_out[OFFW-1:0] : ld_off_q;
  assign al_f3  = (state_q == S_IDLE) ? funct3 : ld_f3_q;

  wb_load_align #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_align (
    .rdata  (mem_rdata),
    .offset (al_off),
    .funct3 (al_f3),
    .data   (al_data),
    .err    (al_err)
  );

  // Non-load result select.
  always_comb begin
    nonload_res = '0;
    case (wb_sel)
      WB_ALU: nonload_res = alu_out;
      WB_PC4: nonload_res = pc_plus4;
`ifdef WB_CSR_EN
      WB_CSR: nonload_res = csr_rdata;
`endif
      default: nonload_res = '0;
    endcase
  end

  // Next-state, load latch and completion logic.
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    retire_d   = 1'b0;
    cmp_c      = 1'b0;
    cmp_rd     = rd;
    cmp_we     = reg_write;
    cmp_data   = nonload_res;
    cmp_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (wb_sel == WB_MEM) begin
            if (mem_rvalid) begin
              cmp_c    = 1'b1;
              cmp_data = al_data;
              cmp_err  = al_err;
            end else begin
              ld_rd_d  = rd;
              ld_we_d  = reg_write;
              ld_f3_d  = funct3;
              ld_off_d = alu_out[OFFW-1:0];
              state_d  = S_WAIT_LOAD;
            end
          end else begin
            cmp_c = 1'b1;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (mem_rvalid) begin
          cmp_c    = 1'b1;
          cmp_rd   = ld_rd_q;
          cmp_we   = ld_we_q;
          cmp_data = al_data;
          cmp_err  = al_err;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address/data always update on completion; enable masks x0 and errors.
    if (cmp_c) begin
      rf_we_d    = cmp_we && (cmp_rd != '0) && !cmp_err;
      rf_waddr_d = cmp_rd;
      rf_wdata_d = cmp_data;
      load_err_d = cmp_err;
      retire_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
      retire_q   <= retire_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign load_err = load_err_q;
  assign retire   = retire_q;

endmodule
